// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and constants for the iterative M-extension unit
// Contents:
//   muldiv_op_t : funct3 encodings of the RV32M/RV64M operations
//   md_state_t  : sequencer states IDLE, BUSY, DONE
//   XLEN_DEF    : default operand width
//   CNT_W       : iteration counter width for the default operand width
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_t;

  localparam int XLEN_DEF = 32;
  localparam int CNT_W    = $clog2(XLEN_DEF);

endpackage

// File: rtl/muldiv_iter_core.sv
// rtl/muldiv_iter_core.sv - radix-2 shift-add / restoring shift-subtract datapath
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   load           : capture acc_in/opnd_in/is_div, clear the step counter
//   step           : perform one radix-2 iteration
//   is_div         : operation class captured on load (1 = divide)
//   opnd_in        : multiplicand magnitude (multiply) or divisor magnitude (divide)
//   acc_in         : initial accumulator, {zeros, multiplier or dividend magnitude}
//   acc_nxt        : accumulator value after the step in progress
//   last           : the step in progress is the final one
module muldiv_iter_core
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int CW   = CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic              is_div,
  input  logic [XLEN-1:0]   opnd_in,
  input  logic [2*XLEN-1:0] acc_in,
  output logic [2*XLEN-1:0] acc_nxt,
  output logic              last
);

  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opnd;
  logic [CW-1:0]     cnt;
  logic              div_q;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     rem_sh;
  logic [XLEN+1:0]   diff;

  // Multiply: upper half accumulates, multiplier bits retire from acc[0]
  // and the product shifts in from the top (carry included).
  // Divide: {remainder, dividend/quotient} shifts left; a quotient bit is
  // set whenever the trial subtraction does not go negative.
  always_comb begin
    mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    rem_sh  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    diff    = {1'b0, rem_sh} - {2'b00, opnd};
    if (div_q) begin
      if (diff[XLEN+1]) begin
        acc_nxt = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      end else begin
        acc_nxt = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      end
    end else begin
      acc_nxt = {mul_sum, acc[XLEN-1:1]};
    end
  end

  assign last = (cnt == CW'(XLEN-1));

  always_ff @(posedge clk) begin
    if (reset) begin
      acc   <= '0;
      opnd  <= '0;
      cnt   <= '0;
      div_q <= 1'b0;
    end else if (load) begin
      acc   <= acc_in;
      opnd  <= opnd_in;
      cnt   <= '0;
      div_q <= is_div;
    end else if (step) begin
      acc   <= acc_nxt;
      cnt   <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - execute-stage iterative multiply/divide unit with stall and done handshake
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   startE, flushE     : M instruction present in E / kill the instruction in E
//   funct3E            : operation select (MUL..REMU)
//   SrcAE, SrcBE, RdE  : forwarded operands and destination register
//   stallMD            : combinational stall request toward the hazard unit
//   doneMD             : one-cycle completion pulse
//   resultMD, RdMD     : registered result and destination, held between operations
// Build option: MULDIV_EARLY_OUT_EN finishes divide-by-zero, signed overflow and
// multiply-by-zero directly from IDLE to DONE.
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            startE,
  input  logic            flushE,
  input  logic [2:0]      funct3E,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  input  logic [4:0]      RdE,
  output logic            stallMD,
  output logic            doneMD,
  output logic [XLEN-1:0] resultMD,
  output logic [4:0]      RdMD
);

`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY_EN = 1'b1;
`else
  localparam bit EARLY_EN = 1'b0;
`endif

  localparam logic [XLEN-1:0] ONES = '1;
  localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};

  md_state_t   state;
  muldiv_op_t  op_in, op_q;
  logic [4:0]  rd_q;
  logic        neg_q, neg_r, dz_q, done_q;
  logic        a_sgn, b_sgn, sa, sb;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic        dz_in, ovf_in, mzero_in, early_hit, accept, core_last;
  logic [XLEN-1:0]   early_res, fin_res, q_mag, r_mag;
  logic [2*XLEN-1:0] acc_init, acc_nxt, prod_fix;
  logic [XLEN-1:0]   opnd_init;

  assign op_in = muldiv_op_t'(funct3E);

  always_comb begin
    a_sgn    = (op_in != OP_MULHU) && (op_in != OP_DIVU) && (op_in != OP_REMU);
    b_sgn    = a_sgn && (op_in != OP_MULHSU);
    sa       = a_sgn & SrcAE[XLEN-1];
    sb       = b_sgn & SrcBE[XLEN-1];
    mag_a    = sa ? -SrcAE : SrcAE;
    mag_b    = sb ? -SrcBE : SrcBE;
    dz_in    = funct3E[2] & (SrcBE == '0);
    ovf_in   = ((op_in == OP_DIV) || (op_in == OP_REM)) && (SrcAE == MINV) && (SrcBE == ONES);
    mzero_in = ~funct3E[2] & ((SrcAE == '0) | (SrcBE == '0));
    // funct3E[1] separates remainder from quotient among the divides
    if (mzero_in)    early_res = '0;
    else if (dz_in)  early_res = funct3E[1] ? SrcAE : ONES;
    else             early_res = funct3E[1] ? '0 : MINV;
    early_hit = EARLY_EN & (dz_in | ovf_in | mzero_in);
    acc_init  = {{XLEN{1'b0}}, (funct3E[2] ? mag_a : mag_b)};
    opnd_init = funct3E[2] ? mag_b : mag_a;
  end

  assign accept  = (state == IDLE) & startE & ~flushE;
  assign stallMD = accept | (state == BUSY);
  assign doneMD  = done_q & ~flushE;

  muldiv_iter_core #(
    .XLEN(XLEN),
    .CW  ($clog2(XLEN))
  ) u_core (
    .clk    (clk),
    .reset  (reset),
    .load   (accept),
    .step   ((state == BUSY) & ~flushE),
    .is_div (funct3E[2]),
    .opnd_in(opnd_init),
    .acc_in (acc_init),
    .acc_nxt(acc_nxt),
    .last   (core_last)
  );

  // Result formed from the final step's value so it is registered on entry to DONE.
  // Signed MIN / -1 needs no special case here: |MIN|/1 = MIN with a positive sign.
  always_comb begin
    prod_fix = neg_q ? -acc_nxt : acc_nxt;
    q_mag    = acc_nxt[XLEN-1:0];
    r_mag    = acc_nxt[2*XLEN-1:XLEN];
    case (op_q)
      OP_MUL:                     fin_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fin_res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:            fin_res = dz_q ? ONES : (neg_q ? -q_mag : q_mag);
      default:                    fin_res = neg_r ? -r_mag : r_mag;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      op_q     <= OP_MUL;
      rd_q     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dz_q     <= 1'b0;
      done_q   <= 1'b0;
      resultMD <= '0;
      RdMD     <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (accept) begin
            op_q  <= op_in;
            rd_q  <= RdE;
            neg_q <= sa ^ sb;
            neg_r <= sa;
            dz_q  <= dz_in;
            if (early_hit) begin
              state    <= DONE;
              done_q   <= 1'b1;
              resultMD <= early_res;
              RdMD     <= RdE;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (flushE) begin
            state <= IDLE;
          end else if (core_last) begin
            state    <= DONE;
            done_q   <= 1'b1;
            resultMD <= fin_res;
            RdMD     <= rd_q;
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          done_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - self-checking bench for ex_muldiv_unit against an arithmetic reference
module tb_ex_muldiv_unit;

  localparam int XLEN = 32;
  localparam logic [31:0] MINV = 32'h8000_0000;

`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, startE, flushE;
  logic [2:0]  funct3E;
  logic [31:0] SrcAE, SrcBE;
  logic [4:0]  RdE;
  logic        stallMD, doneMD;
  logic [31:0] resultMD;
  logic [4:0]  RdMD;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ex_muldiv_unit #(.XLEN(XLEN)) dut (
    .clk     (clk),
    .reset   (reset),
    .startE  (startE),
    .flushE  (flushE),
    .funct3E (funct3E),
    .SrcAE   (SrcAE),
    .SrcBE   (SrcBE),
    .RdE     (RdE),
    .stallMD (stallMD),
    .doneMD  (doneMD),
    .resultMD(resultMD),
    .RdMD    (RdMD)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic [31:0] r;
    logic ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'h0, a});
    ub  = longint'({32'h0, b});
    ovf = (a == MINV) && (b == 32'hFFFF_FFFF);
    p   = '0;
    case (f3)
      3'd0: begin p = sa * sb; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: r = (b == 0) ? 32'hFFFF_FFFF : ovf ? MINV : 32'(sa / sb);
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: r = (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    bit special;
    special = (f3[2] && b == 0) ||
              ((f3 == 3'd4 || f3 == 3'd6) && a == MINV && b == 32'hFFFF_FFFF) ||
              (!f3[2] && (a == 0 || b == 0));
    return (EARLY && special) ? 1 : XLEN + 1;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return MINV;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Entered and left just after a rising edge; startE is held through DONE.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input bit gap);
    int lat, cyc;
    bit got, stall_ok;
    logic [31:0] exp;
    lat = ref_latency(f3, a, b);
    exp = ref_result(f3, a, b);
    startE = 1'b1; funct3E = f3; SrcAE = a; SrcBE = b; RdE = rd;
    @(negedge clk);
    stall_ok = (stallMD === 1'b1) && (doneMD === 1'b0);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      @(negedge clk);
      if (doneMD === 1'b1) got = 1'b1;
      if (stallMD !== (cyc < lat)) stall_ok = 1'b0;
    end
    check($sformatf("%s_lat", tag), 64'(cyc), 64'(lat));
    check($sformatf("%s_stall", tag), 64'(stall_ok), 64'd1);
    check($sformatf("%s_res", tag), 64'(resultMD), 64'(exp));
    check($sformatf("%s_rd", tag), 64'(RdMD), 64'(rd));
    @(posedge clk); #1;
    startE = 1'b0;
    if (gap) begin
      @(negedge clk);
      check($sformatf("%s_idle_stall", tag), 64'(stallMD), 64'd0);
      check($sformatf("%s_idle_done", tag), 64'(doneMD), 64'd0);
      check($sformatf("%s_hold", tag), 64'(resultMD), 64'(exp));
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [31:0] prev_res;
    logic [4:0]  prev_rd;
    reset = 1'b1; startE = 1'b0; flushE = 1'b0;
    funct3E = '0; SrcAE = '0; SrcBE = '0; RdE = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", 64'(stallMD), 64'd0);
    check("rst_done", 64'(doneMD), 64'd0);
    check("rst_res", 64'(resultMD), 64'd0);
    check("rst_rd", 64'(RdMD), 64'd0);
    reset = 1'b0;

    run_op("mulh_min", 3'd1, MINV, MINV, 5'd3, 1'b1);
    run_op("mulhsu_m1", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 1'b0);
    run_op("mul_m1", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 1'b0);
    run_op("div_m7", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd6, 1'b0);
    run_op("rem_m7", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd7, 1'b0);
    run_op("divu_z", 3'd5, 32'd7, 32'd0, 5'd8, 1'b0);
    run_op("remu_z", 3'd7, 32'd7, 32'd0, 5'd9, 1'b0);
    run_op("div_ovf", 3'd4, MINV, 32'hFFFF_FFFF, 5'd10, 1'b0);
    run_op("rem_ovf", 3'd6, MINV, 32'hFFFF_FFFF, 5'd11, 1'b1);
    run_op("mul_z", 3'd0, 32'd0, 32'h1234_5678, 5'd12, 1'b1);

    // Flush a DIVU in its tenth cycle; the next MUL starts right after.
    prev_res = resultMD;
    prev_rd  = RdMD;
    startE = 1'b1; funct3E = 3'd5; SrcAE = 32'd1000; SrcBE = 32'd7; RdE = 5'd20;
    repeat (10) begin @(posedge clk); #1; end
    flushE = 1'b1;
    @(negedge clk);
    check("flush_done10", 64'(doneMD), 64'd0);
    @(posedge clk); #1;
    flushE = 1'b0; startE = 1'b0;
    #1;
    check("flush_stall11", 64'(stallMD), 64'd0);
    check("flush_done11", 64'(doneMD), 64'd0);
    check("flush_res", 64'(resultMD), 64'(prev_res));
    check("flush_rd", 64'(RdMD), 64'(prev_rd));
    run_op("mul_after_flush", 3'd0, 32'd1234, 32'd5678, 5'd21, 1'b1);

    // Reset mid-operation.
    startE = 1'b1; funct3E = 3'd1; SrcAE = 32'h1234_5678; SrcBE = 32'h9ABC_DEF0; RdE = 5'd22;
    repeat (5) begin @(posedge clk); #1; end
    reset = 1'b1; startE = 1'b0;
    @(posedge clk); #1;
    check("rst5_stall", 64'(stallMD), 64'd0);
    check("rst5_done", 64'(doneMD), 64'd0);
    check("rst5_res", 64'(resultMD), 64'd0);
    check("rst5_rd", 64'(RdMD), 64'd0);
    reset = 1'b0;
    run_op("after_rst", 3'd6, 32'd100, 32'hFFFF_FFFD, 5'd23, 1'b1);

    for (int i = 0; i < 30; i++) begin
      run_op($sformatf("rnd%0d", i), 3'($urandom_range(0, 7)), pick(), pick(),
             5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
